// File: rtl/rect_finder_pkg.sv
// Shared definitions for the rectangle-loop datapath (finder + flip unit).
// Holds the finder FSM state type and the MSB-first matrix bit mapping
// that both blocks must agree on.
package rect_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    RESULT = 2'd2
  } state_t;

  // Element (r,c) of a rows x cols matrix lives at this bit of the flat
  // vector; (0,0) is the MSB.
  function automatic int bit_index(input int r, input int c,
                                   input int rows, input int cols);
    return rows*cols - 1 - (r*cols + c);
  endfunction

endpackage

// File: rtl/rect_finder_if.sv
// Request/result bundle between a scan requester and rect_finder.
//   master : drives start, m_in, res_ready; observes busy/result
//   slave  : the finder itself
interface rect_finder_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic                 start;
  logic [ROWS*COLS-1:0] m_in;
  logic                 busy;
  logic                 res_valid;
  logic                 res_ready;
  logic                 found;
  logic [RW-1:0]        r1;
  logic [RW-1:0]        r2;
  logic [CW-1:0]        c1;
  logic [CW-1:0]        c2;

  modport master (
    output start, m_in, res_ready,
    input  busy, res_valid, found, r1, r2, c1, c2
  );

  modport slave (
    input  start, m_in, res_ready,
    output busy, res_valid, found, r1, r2, c1, c2
  );
endinterface

// File: rtl/rect_col_pick.sv
// Combinational column picker for one ANDed row pair.
//   i_vec  : COLS-bit vector, bit c = column c has a 1 in both rows
//   o_hit  : at least two columns set (a rectangle exists for this pair)
//   o_lo   : lowest set column index
//   o_hi   : second-lowest set column index
module rect_col_pick #(
  parameter  int COLS = 4,
  localparam int CW   = $clog2(COLS)
) (
  input  logic [COLS-1:0] i_vec,
  output logic            o_hit,
  output logic [CW-1:0]   o_lo,
  output logic [CW-1:0]   o_hi
);

  // Saturating count: only "0, 1, >=2" matters.
  logic [1:0] w_cnt;

  always_comb begin
    w_cnt = 2'd0;
    o_lo  = '0;
    o_hi  = '0;
    for (int c = 0; c < COLS; c++) begin
      if (i_vec[c]) begin
        if (w_cnt == 2'd0) o_lo = CW'(c);
        else if (w_cnt == 2'd1) o_hi = CW'(c);
        if (w_cnt != 2'd2) w_cnt = w_cnt + 2'd1;
      end
    end
    o_hit = (w_cnt == 2'd2);
  end

endmodule

// File: rtl/rect_finder.sv
// Finds the first axis-aligned rectangle with four 1-corners in a captured
// ROWS x COLS binary matrix, testing one row pair per cycle.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of rect_finder_if (start/m_in request, registered
//          busy/res_valid/found/r1/r2/c1/c2 result, res_ready accept)
// Pair order: r1 ascending, r2 ascending from r1+1. A hit latches the two
// lowest common columns; exhausting all pairs reports found=0 with zeroed
// coordinates.
module rect_finder
  import rect_pkg::*;
#(
  parameter  int ROWS = 4,
  parameter  int COLS = 4,
  localparam int RW   = $clog2(ROWS),
  localparam int CW   = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  rect_finder_if.slave  bus
);

  localparam logic [RW-1:0] LAST_R2 = RW'(ROWS-1);
  localparam logic [RW-1:0] LAST_R1 = RW'(ROWS-2);

  state_t               r_state, w_state_n;
  logic [ROWS*COLS-1:0] r_mat;
  logic [RW-1:0]        r_pr1, r_pr2;

  logic                 r_busy, r_valid, r_found;
  logic [RW-1:0]        r_r1, r_r2;
  logic [CW-1:0]        r_c1, r_c2;

  logic [ROWS-1:0][COLS-1:0] w_rows;
  logic [COLS-1:0]      w_and;
  logic                 w_hit;
  logic [CW-1:0]        w_lo, w_hi;
  logic                 w_last;
  logic                 w_accept;

  // Unflatten the captured matrix into rows; bit c of a row is column c.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign w_rows[r][c] = r_mat[bit_index(r, c, ROWS, COLS)];
    end
  end

  assign w_and = w_rows[r_pr1] & w_rows[r_pr2];

  rect_col_pick #(.COLS(COLS)) u_pick (
    .i_vec (w_and),
    .o_hit (w_hit),
    .o_lo  (w_lo),
    .o_hi  (w_hi)
  );

  assign w_last   = (r_pr1 == LAST_R1) && (r_pr2 == LAST_R2);
  assign w_accept = (r_state == IDLE) && bus.start;

  // Next-state logic
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_n = SCAN;
      SCAN:    if (w_hit || w_last) w_state_n = RESULT;
      RESULT:  if (bus.res_ready) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // State register; busy/valid are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_busy  <= (w_state_n != IDLE);
      r_valid <= (w_state_n == RESULT);
    end
  end

  // Matrix capture, pair counters and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mat   <= '0;
      r_pr1   <= '0;
      r_pr2   <= '0;
      r_found <= 1'b0;
      r_r1    <= '0;
      r_r2    <= '0;
      r_c1    <= '0;
      r_c2    <= '0;
    end else if (w_accept) begin
      r_mat <= bus.m_in;
      r_pr1 <= '0;
      r_pr2 <= RW'(1);
    end else if (r_state == SCAN) begin
      if (w_hit) begin
        r_found <= 1'b1;
        r_r1    <= r_pr1;
        r_r2    <= r_pr2;
        r_c1    <= w_lo;
        r_c2    <= w_hi;
      end else if (w_last) begin
        r_found <= 1'b0;
        r_r1    <= '0;
        r_r2    <= '0;
        r_c1    <= '0;
        r_c2    <= '0;
      end else if (r_pr2 == LAST_R2) begin
        // Wrap: next r1, r2 restarts just above it. Never reached with the
        // terminal pair, so r1+2 stays in range.
        r_pr1 <= r_pr1 + RW'(1);
        r_pr2 <= r_pr1 + RW'(2);
      end else begin
        r_pr2 <= r_pr2 + RW'(1);
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.res_valid = r_valid;
  assign bus.found     = r_found;
  assign bus.r1        = r_r1;
  assign bus.r2        = r_r2;
  assign bus.c1        = r_c1;
  assign bus.c2        = r_c2;

endmodule

// File: tb/tb_rect_finder.sv
module tb_rect_finder;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int P    = ROWS*(ROWS-1)/2;

  typedef struct {
    bit found;
    int r1, r2, c1, c2;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rect_finder_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  rect_finder #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference: walk row pairs in spec order, collect common columns.
  function automatic bit mbit(input logic [15:0] m, input int r, input int c);
    return m[ROWS*COLS-1-(r*COLS+c)];
  endfunction

  function automatic exp_t model(input logic [15:0] m);
    exp_t e;
    int   k;
    int   cols[$];
    e = '{found: 0, r1: 0, r2: 0, c1: 0, c2: 0, lat: P+1};
    k = 0;
    for (int a = 0; a < ROWS; a++)
      for (int b = a+1; b < ROWS; b++) begin
        cols.delete();
        for (int c = 0; c < COLS; c++)
          if (mbit(m, a, c) && mbit(m, b, c)) cols.push_back(c);
        if (cols.size() >= 2 && !e.found) begin
          e = '{found: 1, r1: a, r2: b, c1: cols[0], c2: cols[1], lat: k+2};
        end
        k++;
      end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input exp_t e);
    chk({tag, "_valid"}, 32'(bus.res_valid), 1);
    chk({tag, "_busy"},  32'(bus.busy), 1);
    chk({tag, "_found"}, 32'(bus.found), 32'(e.found));
    chk({tag, "_r1"},    32'(bus.r1), 32'(e.r1));
    chk({tag, "_r2"},    32'(bus.r2), 32'(e.r2));
    chk({tag, "_c1"},    32'(bus.c1), 32'(e.c1));
    chk({tag, "_c2"},    32'(bus.c2), 32'(e.c2));
  endtask

  // Start a scan (cycle 0 = edge sampling start) and wait for res_valid.
  task automatic scan(input logic [15:0] m, input string tag);
    exp_t e;
    int   cyc;
    e = model(m);
    @(negedge clk);
    bus.start = 1'b1;
    bus.m_in  = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.m_in  = 16'($urandom);
    cyc = 1;
    while (bus.res_valid !== 1'b1 && cyc < 40) begin
      chk({tag, "_busy_scan"}, 32'(bus.busy), 1);
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(e.lat));
    chk_result(tag, e);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk({tag, "_hs_valid"}, 32'(bus.res_valid), 0);
    chk({tag, "_hs_busy"},  32'(bus.busy), 0);
  endtask

  initial begin
    exp_t e;
    logic [15:0] m;
    bus.start     = 1'b0;
    bus.m_in      = '0;
    bus.res_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_valid", 32'(bus.res_valid), 0);
    chk("rst_found", 32'(bus.found), 0);
    chk("rst_coord", 32'({bus.r1, bus.r2, bus.c1, bus.c2}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    scan(16'h0550, "d0550"); handshake("d0550");
    scan(16'hFFFF, "dFFFF"); handshake("dFFFF");
    scan(16'hE00E, "dE00E"); handshake("dE00E");
    scan(16'h0000, "d0000"); handshake("d0000");

    // Backpressure: outputs hold, start and m_in ignored
    scan(16'h0550, "bp");
    e = model(16'h0550);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.m_in  = 16'hFFFF ^ 16'(i);
      @(posedge clk); #1;
      chk_result("bp_hold", e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    handshake("bp");
    @(posedge clk); #1;
    chk("bp_noqueue_busy", 32'(bus.busy), 0);

    // Reset in cycle 3 of an empty-matrix scan
    @(negedge clk);
    bus.start = 1'b1;
    bus.m_in  = 16'h0000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy",  32'(bus.busy), 0);
    chk("midrst_valid", 32'(bus.res_valid), 0);
    chk("midrst_found", 32'(bus.found), 0);
    chk("midrst_coord", 32'({bus.r1, bus.r2, bus.c1, bus.c2}), 0);
    @(negedge clk);
    rst = 1'b0;
    scan(16'hFFFF, "postrst"); handshake("postrst");

    // rst and start together: rst wins
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.m_in  = 16'hFFFF;
    @(posedge clk); #1;
    chk("rststart_busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("rststart_idle", 32'(bus.busy), 0);

    // Randomized scans with random result backpressure
    for (int i = 0; i < 40; i++) begin
      m = (i % 2 == 0) ? 16'($urandom & $urandom) : 16'($urandom);
      scan(m, "rnd");
      e = model(m);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        chk_result("rnd_hold", e);
      end
      handshake("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_finder.md
# rect_finder

Scans a ROWS×COLS binary matrix for the first axis-aligned rectangle whose four corners are all 1. Reports that rectangle as corner coordinates (r1, r2, c1, c2) in the same encoding the corner-flip unit consumes, so the two blocks chain directly: finder selects a rectangle, flip unit toggles it. It tests one row pair per cycle behind a start/result valid-ready handshake and sits upstream of the flip stage in the rectangle-loop datapath.

## Interface
- ROWS, default 4, matrix row count (≥2)
- COLS, default 4, matrix column count (≥2)
- RW, default $clog2(ROWS), row-coordinate width (derived, not overridden)
- CW, default $clog2(COLS), column-coordinate width (derived, not overridden)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a scan; accepted only in IDLE
- m_in  in  ROWS*COLS  matrix; element (r,c) at bit ROWS*COLS-1-(r*COLS+c), so (0,0) is the MSB
- busy  out  1  high in SCAN and RESULT
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- found  out  1  1 = rectangle found, 0 = none exists
- r1, r2  out  RW each  corner rows, r1 < r2
- c1, c2  out  CW each  corner columns, c1 < c2

## Operation
- States: IDLE → SCAN → RESULT → IDLE.
- IDLE: on start=1, capture m_in into an internal register; clear pair counters to (r1=0, r2=1); go to SCAN. m_in is ignored at all other times.
- SCAN: each cycle, AND captured rows r1 and r2. If ≥2 bits are set, latch c1/c2 as the two lowest set column indices, latch r1/r2, set found=1, go to RESULT. Otherwise advance to the next pair.
- Pair order: r1 ascending; for each r1, r2 ascending from r1+1. Pair index k runs 0 … P-1, where P = ROWS*(ROWS-1)/2.
- Wrap: when r2 = ROWS-1, r1 increments and r2 becomes r1+1.
- Exhaustion: a miss on pair P-1 goes to RESULT with found=0 and r1=r2=c1=c2=0.
- RESULT: res_valid=1. found and the coordinates stay stable until res_valid && res_ready, then the block returns to IDLE.
- start is ignored while busy=1. A start pulse is never queued.
- Counter arithmetic is unsigned and wide enough for ROWS-1 / COLS-1. There is no overflow path, because the terminal pair ends the scan.

## Timing
- Reset values: busy=0, res_valid=0, found=0, r1=r2=c1=c2=0; state=IDLE; captured matrix cleared.
- Cycle numbering: the cycle in which start is sampled high in IDLE is cycle 0.
- SCAN tests pair k in cycle k+1.
- A hit on pair k asserts res_valid in cycle k+2.
- No rectangle: res_valid asserts in cycle P+1 (cycle 7 for 4×4).
- Handshake: res_valid drops in the cycle after the res_ready handshake. A new start is accepted no earlier than that cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- rst mid-scan or in RESULT forces reset values on the next edge, and any pending result is discarded.
- rst and start high in the same cycle: rst wins.

## Structure
- Shared package rect_pkg holds:
  - state typedef (enum: IDLE, SCAN, RESULT);
  - function bit_index(r, c, ROWS, COLS), the MSB-first mapping shared with the flip unit.
- Sub-module rect_col_pick: combinational, COLS-bit input. Outputs hit (popcount ≥ 2) and the lowest two set indices lo, hi.
- Top level holds the FSM, pair counters, matrix register and output registers.

## Test plan
All cases use ROWS = COLS = 4.
- m_in=16'h0550 (corners (1,1),(1,3),(2,1),(2,3)), start in cycle 0 → res_valid in cycle 5 (k=3), found=1, r1=1, r2=2, c1=1, c2=3.
- m_in=16'hFFFF → res_valid in cycle 2, found=1, r1=0, r2=1, c1=0, c2=1.
- m_in=16'hE00E (rows 0 and 3 set at columns 0–2) → res_valid in cycle 4, r1=0, r2=3, c1=0, c2=1 (lowest two columns chosen).
- m_in=16'h0000 → res_valid in cycle 7, found=0, all coordinates 0.
- Backpressure: after a result, hold res_ready=0 for 5 cycles, pulse start and change m_in meanwhile → outputs stable, start ignored, busy=1. After the handshake, busy=0 in the next cycle.
- rst asserted in cycle 3 of a 16'h0000 scan → all reset values next cycle. A fresh start on 16'hFFFF then completes normally in 2 cycles.
